// File: rtl/dac_mon_pkg.sv
// Shared definitions for the AD5754 serial-bus monitor.
//   FRAME_BITS_DEF     : default frame length in bits
//   REG_DAC / ADDR_ALL : register-select and address codes that drive the mirror
//   *_BIT / *_MSB/LSB  : field positions inside a 24-bit frame
//   monState_t         : deserializer state encoding
package dac_mon_pkg;

  localparam int FRAME_BITS_DEF = 24;

  localparam logic [2:0] REG_DAC  = 3'b000;
  localparam logic [2:0] ADDR_ALL = 3'b100;

  localparam int RW_BIT   = 23;
  localparam int ZERO_BIT = 22;
  localparam int REG_MSB  = 21;
  localparam int REG_LSB  = 19;
  localparam int ADDR_MSB = 18;
  localparam int ADDR_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } monState_t;

endpackage

// File: rtl/dac_serial_monitor_if.sv
// Taps of the AD5754 serial bus as seen at the DAC pins.
//   master : the side that drives the DAC lines (transmitter or bench)
//   slave  : the monitor, which only observes them
//   monSync / monLoad / monClr are active low; monSclk idles high.
interface dac_serial_monitor_if;
  logic monSync;
  logic monSclk;
  logic monSdin;
  logic monLoad;
  logic monClr;

  modport master (output monSync, output monSclk, output monSdin,
                  output monLoad, output monClr);
  modport slave  (input monSync, input monSclk, input monSdin,
                  input monLoad, input monClr);
endinterface

// File: rtl/dac_mon_sync_edge.sv
// Synchronizer plus edge detector for one monitored line.
//   sysClk, Reset : system clock, synchronous active-high reset
//   din           : asynchronous tap
//   level         : synchronized level (after STAGES flops)
//   rise / fall   : one-cycle pulses on synchronized edges
module dac_mon_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic sysClk,
  input  logic Reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] syncSr;
  logic              prevLvl;
  logic [STAGES:0]   primeSr;

  // The chain comes out of reset at the idle level. If the real line is
  // already away from idle, the first true samples would look like an edge;
  // primeSr masks edges until the chain and prevLvl hold real samples, so
  // a frame already in progress at reset release is never picked up.
  always_ff @(posedge sysClk) begin
    if (Reset) begin
      syncSr  <= {STAGES{RESET_VAL}};
      prevLvl <= RESET_VAL;
      primeSr <= '0;
    end else begin
      syncSr  <= {syncSr[STAGES-2:0], din};
      prevLvl <= syncSr[STAGES-1];
      primeSr <= {primeSr[STAGES-1:0], 1'b1};
    end
  end

  assign level = syncSr[STAGES-1];
  assign rise  = primeSr[STAGES] & ~prevLvl &  level;
  assign fall  = primeSr[STAGES] &  prevLvl & ~level;

endmodule

// File: rtl/dac_serial_monitor.sv
// Receive-side monitor for the AD5754 serial DAC interface. Deserializes
// 24-bit frames (MSB first, sampled on SCLK falling edges), decodes them,
// mirrors the DAC data/output registers and flags framing errors.
//   sysClk, Reset       : system clock, synchronous active-high reset
//   monBus              : observed SYNC/SCLK/SDIN/LDAC/CLR lines
//   frameValid          : one-cycle pulse per good frame
//   frameRw/Reg/Addr/Data : fields of the last good frame
//   chX_dreg / chX_out  : mirrored data and output registers
//   frameCnt / errCnt   : good-frame and framing-error counters (wrapping)
//   errLen              : one-cycle pulse per framing error
//   errZero             : sticky, a frame had its reserved zero bit set
//
// state | meaning
// IDLE  | waiting for SYNC falling edge
// SHIFT | SYNC low, shifting one bit per SCLK falling edge
// DONE  | one cycle: publish fields, update mirror registers
module dac_serial_monitor
  import dac_mon_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 sysClk,
  input  logic                 Reset,
  dac_serial_monitor_if.slave  monBus,
  output logic                 frameValid,
  output logic                 frameRw,
  output logic [2:0]           frameReg,
  output logic [2:0]           frameAddr,
  output logic [15:0]          frameData,
  output logic [15:0]          chA_dreg,
  output logic [15:0]          chB_dreg,
  output logic [15:0]          chC_dreg,
  output logic [15:0]          chD_dreg,
  output logic [15:0]          chA_out,
  output logic [15:0]          chB_out,
  output logic [15:0]          chC_out,
  output logic [15:0]          chD_out,
  output logic [CNT_W-1:0]     frameCnt,
  output logic [CNT_W-1:0]     errCnt,
  output logic                 errLen,
  output logic                 errZero
);

  localparam int BCNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_BITS);
  localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(FRAME_BITS + 1);

  logic syncLvl, syncRise, syncFall;
  logic sclkLvl, sclkRise, sclkFall;
  logic sdinLvl, sdinRise, sdinFall;
  logic loadLvl, loadRise, loadFall;
  logic clrLvl,  clrRise,  clrFall;

  dac_mon_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSync (
    .sysClk(sysClk), .Reset(Reset), .din(monBus.monSync),
    .level(syncLvl), .rise(syncRise), .fall(syncFall));
  dac_mon_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSclk (
    .sysClk(sysClk), .Reset(Reset), .din(monBus.monSclk),
    .level(sclkLvl), .rise(sclkRise), .fall(sclkFall));
  dac_mon_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSdin (
    .sysClk(sysClk), .Reset(Reset), .din(monBus.monSdin),
    .level(sdinLvl), .rise(sdinRise), .fall(sdinFall));
  dac_mon_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uLoad (
    .sysClk(sysClk), .Reset(Reset), .din(monBus.monLoad),
    .level(loadLvl), .rise(loadRise), .fall(loadFall));
  dac_mon_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uClr (
    .sysClk(sysClk), .Reset(Reset), .din(monBus.monClr),
    .level(clrLvl), .rise(clrRise), .fall(clrFall));

  logic unusedEdges;
  assign unusedEdges = ^{syncLvl, sclkLvl, sclkRise, sdinRise, sdinFall,
                         loadLvl, loadRise, clrRise, clrFall};

  monState_t             state;
  logic [FRAME_BITS-1:0] shiftReg, shiftNext;
  logic [BCNT_W-1:0]     bitCnt, cntNext;
  logic [15:0]           dreg   [4];
  logic [15:0]           outReg [4];

  logic       doneRw;
  logic [2:0] doneReg, doneAddr;
  logic [15:0] doneData;

  assign doneRw   = shiftReg[RW_BIT];
  assign doneReg  = shiftReg[REG_MSB:REG_LSB];
  assign doneAddr = shiftReg[ADDR_MSB:ADDR_LSB];
  assign doneData = shiftReg[15:0];

  // Shift happens before the count is judged, so an SCLK fall landing in
  // the same cycle as the SYNC rise still counts toward the frame.
  always_comb begin
    shiftNext = shiftReg;
    cntNext   = bitCnt;
    if (sclkFall) begin
      shiftNext = {shiftReg[FRAME_BITS-2:0], sdinLvl};
      if (bitCnt != BCNT_SAT) cntNext = bitCnt + 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (Reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      frameValid <= 1'b0;
      frameRw    <= 1'b0;
      frameReg   <= '0;
      frameAddr  <= '0;
      frameData  <= '0;
      frameCnt   <= '0;
      errCnt     <= '0;
      errLen     <= 1'b0;
      errZero    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dreg[i]   <= '0;
        outReg[i] <= '0;
      end
    end else begin
      frameValid <= 1'b0;
      errLen     <= 1'b0;

      case (state)
        IDLE: begin
          if (syncFall) begin
            shiftReg <= '0;
            bitCnt   <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shiftReg <= shiftNext;
          bitCnt   <= cntNext;
          if (syncRise) begin
            if (cntNext == BCNT_FULL) begin
              state <= DONE;
            end else if (cntNext == '0) begin
              state <= IDLE;
            end else begin
              errLen <= 1'b1;
              errCnt <= errCnt + 1'b1;
              state  <= IDLE;
            end
          end
        end
        DONE: begin
          frameRw    <= doneRw;
          frameReg   <= doneReg;
          frameAddr  <= doneAddr;
          frameData  <= doneData;
          frameValid <= 1'b1;
          frameCnt   <= frameCnt + 1'b1;
          if (shiftReg[ZERO_BIT]) errZero <= 1'b1;
          if (!doneRw && doneReg == REG_DAC) begin
            if (doneAddr == ADDR_ALL) begin
              for (int i = 0; i < 4; i++) dreg[i] <= doneData;
            end else if (!doneAddr[2]) begin
              dreg[doneAddr[1:0]] <= doneData;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Non-blocking reads of dreg give the pre-DONE values when LDAC
      // coincides with a write. CLR held low overrides LDAC.
      if (!clrLvl) begin
        for (int i = 0; i < 4; i++) outReg[i] <= '0;
      end else if (loadFall) begin
        for (int i = 0; i < 4; i++) outReg[i] <= dreg[i];
      end
    end
  end

  assign chA_dreg = dreg[0];
  assign chB_dreg = dreg[1];
  assign chC_dreg = dreg[2];
  assign chD_dreg = dreg[3];
  assign chA_out  = outReg[0];
  assign chB_out  = outReg[1];
  assign chC_out  = outReg[2];
  assign chD_out  = outReg[3];

endmodule

// File: tb/tb_dac_serial_monitor.sv
// Self-checking bench for dac_serial_monitor: drives frames on the serial
// taps, keeps a queue of expected decoded frames plus a register model.
module tb_dac_serial_monitor;
  import dac_mon_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;

  logic sysClk = 1'b0;
  logic Reset  = 1'b1;
  always #5 sysClk = ~sysClk;

  dac_serial_monitor_if bus();

  logic             frameValid, frameRw, errLen, errZero;
  logic [2:0]       frameReg, frameAddr;
  logic [15:0]      frameData;
  logic [15:0]      chA_dreg, chB_dreg, chC_dreg, chD_dreg;
  logic [15:0]      chA_out, chB_out, chC_out, chD_out;
  logic [CNT_W-1:0] frameCnt, errCnt;

  dac_serial_monitor #(.FRAME_BITS(24), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .sysClk(sysClk), .Reset(Reset), .monBus(bus),
    .frameValid(frameValid), .frameRw(frameRw), .frameReg(frameReg),
    .frameAddr(frameAddr), .frameData(frameData),
    .chA_dreg(chA_dreg), .chB_dreg(chB_dreg), .chC_dreg(chC_dreg), .chD_dreg(chD_dreg),
    .chA_out(chA_out), .chB_out(chB_out), .chC_out(chC_out), .chD_out(chD_out),
    .frameCnt(frameCnt), .errCnt(errCnt), .errLen(errLen), .errZero(errZero));

  logic [15:0] dregP [4];
  logic [15:0] outP  [4];
  assign dregP[0] = chA_dreg;  assign dregP[1] = chB_dreg;
  assign dregP[2] = chC_dreg;  assign dregP[3] = chD_dreg;
  assign outP[0]  = chA_out;   assign outP[1]  = chB_out;
  assign outP[2]  = chC_out;   assign outP[3]  = chD_out;

  typedef struct {
    logic        rw;
    logic [2:0]  rg;
    logic [2:0]  addr;
    logic [15:0] data;
  } expFrame_t;

  expFrame_t   expQ[$];
  expFrame_t   popped;
  logic [15:0] expDreg [4];
  logic [15:0] expOut  [4];
  bit          clrLow = 1'b0;
  int          expFrameCnt = 0;
  int          expErrCnt = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          validSeen = 0;
  int          errSeen = 0;

  // Scoreboard: every good frame the DUT reports must match the next expectation.
  always @(negedge sysClk) begin
    if (frameValid) begin
      validSeen++;
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("FAIL scoreboard_unexpected: got rw=%0d reg=%0d addr=%0d data=%h, required no frame",
                 frameRw, frameReg, frameAddr, frameData);
      end else begin
        popped = expQ.pop_front();
        if ({frameRw, frameReg, frameAddr, frameData} !== {popped.rw, popped.rg, popped.addr, popped.data}) begin
          testsFailed++;
          $display("FAIL scoreboard_fields: got rw=%0d reg=%0d addr=%0d data=%h, required rw=%0d reg=%0d addr=%0d data=%h",
                   frameRw, frameReg, frameAddr, frameData, popped.rw, popped.rg, popped.addr, popped.data);
        end
      end
    end
    if (errLen) errSeen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysClk);
    #1;
  endtask

  task automatic clockBits(input logic [31:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.monSdin = word[i];
      bus.monSclk = 1'b1;
      tick(4);
      bus.monSclk = 1'b0;
      tick(4);
    end
  endtask

  task automatic shiftBits(input logic [31:0] word, input int n);
    bus.monSync = 1'b0;
    tick(4);
    clockBits(word, n);
  endtask

  task automatic endFrame();
    bus.monSync = 1'b1;
    bus.monSclk = 1'b1;
  endtask

  task automatic expectFrame(input logic [23:0] f);
    expFrame_t e;
    e.rw = f[23]; e.rg = f[21:19]; e.addr = f[18:16]; e.data = f[15:0];
    expQ.push_back(e);
    expFrameCnt++;
  endtask

  task automatic applyWrite(input logic [23:0] f);
    if (!f[23] && f[21:19] == 3'b000) begin
      if (f[18:16] == 3'b100) begin
        for (int i = 0; i < 4; i++) expDreg[i] = f[15:0];
      end else if (!f[18]) begin
        expDreg[f[17:16]] = f[15:0];
      end
    end
  endtask

  task automatic waitValid(output int cyc, output bit found);
    cyc = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge sysClk);
      @(negedge sysClk);
      cyc++;
      if (frameValid) found = 1'b1;
    end
  endtask

  task automatic sendFrame(input logic [23:0] f, input bit checkLat);
    int cyc;
    bit found;
    expectFrame(f);
    shiftBits({8'h00, f}, 24);
    endFrame();
    waitValid(cyc, found);
    applyWrite(f);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("FAIL frame_timeout: frame %h got no frameValid within 20 cycles, required a pulse", f);
    end else if (checkLat && cyc !== SYNC_STAGES + 2) begin
      testsFailed++;
      $display("FAIL frame_latency: got %0d cycles, required %0d", cyc, SYNC_STAGES + 2);
    end
    tick(3);
  endtask

  task automatic ldacPulse();
    bus.monLoad = 1'b0;
    tick(4);
    bus.monLoad = 1'b1;
    tick(6);
    if (!clrLow) for (int i = 0; i < 4; i++) expOut[i] = expDreg[i];
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (dregP[i] !== expDreg[i]) begin
        testsFailed++;
        $display("FAIL %s_dreg%0d: got %h, required %h", tag, i, dregP[i], expDreg[i]);
      end
      testsRun++;
      if (outP[i] !== expOut[i]) begin
        testsFailed++;
        $display("FAIL %s_out%0d: got %h, required %h", tag, i, outP[i], expOut[i]);
      end
    end
  endtask

  task automatic checkCounts(input string tag);
    testsRun++;
    if (frameCnt !== CNT_W'(expFrameCnt)) begin
      testsFailed++;
      $display("FAIL %s_frameCnt: got %0d, required %0d", tag, frameCnt, expFrameCnt);
    end
    testsRun++;
    if (errCnt !== CNT_W'(expErrCnt)) begin
      testsFailed++;
      $display("FAIL %s_errCnt: got %0d, required %0d", tag, errCnt, expErrCnt);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      expDreg[i] = '0;
      expOut[i]  = '0;
    end
    expQ.delete();
    expFrameCnt = 0;
    expErrCnt   = 0;
  endtask

  task automatic test_reset();
    bus.monSync = 1'b1; bus.monSclk = 1'b1; bus.monSdin = 1'b0;
    bus.monLoad = 1'b1; bus.monClr  = 1'b1;
    Reset = 1'b1;
    resetModel();
    tick(4);
    testsRun++;
    if ({frameValid, errLen, errZero, frameRw, frameReg, frameAddr, frameData} !== '0) begin
      testsFailed++;
      $display("FAIL reset_flags: got valid=%0d errLen=%0d errZero=%0d data=%h, required all 0",
               frameValid, errLen, errZero, frameData);
    end
    checkCounts("reset");
    checkRegs("reset");
    Reset = 1'b0;
    tick(6);
  endtask

  task automatic test_single_write();
    int v0 = validSeen;
    sendFrame(24'h001234, 1'b1);
    testsRun++;
    if (frameData !== 16'h1234) begin
      testsFailed++;
      $display("FAIL single_frameData: got %h, required 1234", frameData);
    end
    testsRun++;
    if (validSeen - v0 !== 1) begin
      testsFailed++;
      $display("FAIL single_pulses: got %0d frameValid pulses, required 1", validSeen - v0);
    end
    testsRun++;
    if (errZero !== 1'b0) begin
      testsFailed++;
      $display("FAIL single_errZero: got %0d, required 0", errZero);
    end
    checkCounts("single");
    checkRegs("single");
  endtask

  task automatic test_broadcast();
    sendFrame(24'h04ABCD, 1'b1);
    checkRegs("bcast_pre_ldac");
    ldacPulse();
    checkRegs("bcast_ldac");
    checkCounts("bcast");
  endtask

  task automatic test_framing_errors();
    int v0 = validSeen;
    int e0 = errSeen;
    shiftBits(32'h000A_BCDE, 20);
    endFrame();
    tick(12);
    expErrCnt++;
    testsRun++;
    if (errSeen - e0 !== 1) begin
      testsFailed++;
      $display("FAIL err20_pulse: got %0d errLen pulses, required 1", errSeen - e0);
    end
    checkCounts("err20");
    shiftBits(32'h01AB_CDEF, 25);
    endFrame();
    tick(12);
    expErrCnt++;
    checkCounts("err25");
    // SYNC low/high with no clocks is silently dropped.
    bus.monSync = 1'b0;
    tick(4);
    endFrame();
    tick(12);
    checkCounts("err0");
    testsRun++;
    if (errSeen - e0 !== 2 || validSeen !== v0) begin
      testsFailed++;
      $display("FAIL err_pulses: got errLen=%0d valid=%0d, required errLen=2 valid=0",
               errSeen - e0, validSeen - v0);
    end
    checkRegs("err");
  endtask

  task automatic test_decode_only();
    sendFrame(24'hC35555, 1'b0);
    testsRun++;
    if (errZero !== 1'b1) begin
      testsFailed++;
      $display("FAIL zero_bit_errZero: got %0d, required 1", errZero);
    end
    sendFrame(24'h081111, 1'b0);
    sendFrame(24'h052222, 1'b0);
    testsRun++;
    if (frameAddr !== 3'd5 || frameData !== 16'h2222) begin
      testsFailed++;
      $display("FAIL decode_fields: got addr=%0d data=%h, required addr=5 data=2222", frameAddr, frameData);
    end
    checkRegs("decode_only");
    checkCounts("decode_only");
  endtask

  task automatic test_clear();
    bit zeroSeen = 1'b0;
    sendFrame(24'h018000, 1'b0);
    ldacPulse();
    checkRegs("clr_pre");
    bus.monClr = 1'b0;
    clrLow = 1'b1;
    for (int k = 0; k < SYNC_STAGES + 2 && !zeroSeen; k++) begin
      tick(1);
      if (chB_out === 16'h0000) zeroSeen = 1'b1;
    end
    testsRun++;
    if (!zeroSeen) begin
      testsFailed++;
      $display("FAIL clr_latency: chB_out got %h after %0d cycles, required 0000", chB_out, SYNC_STAGES + 2);
    end
    for (int i = 0; i < 4; i++) expOut[i] = '0;
    tick(2);
    checkRegs("clr_low");
    ldacPulse();
    checkRegs("clr_over_ldac");
    bus.monClr = 1'b1;
    clrLow = 1'b0;
    tick(6);
    checkRegs("clr_release");
    ldacPulse();
    checkRegs("clr_then_ldac");
  endtask

  task automatic test_ldac_done();
    int v0;
    sendFrame(24'h020100, 1'b0);
    checkRegs("ldac_done_pre");
    v0 = validSeen;
    expectFrame(24'h02FFFF);
    shiftBits(32'h0002_FFFF, 24);
    endFrame();
    tick(1);
    bus.monLoad = 1'b0;
    tick(4);
    bus.monLoad = 1'b1;
    tick(6);
    for (int i = 0; i < 4; i++) expOut[i] = expDreg[i];
    applyWrite(24'h02FFFF);
    testsRun++;
    if (validSeen - v0 !== 1) begin
      testsFailed++;
      $display("FAIL ldac_done_valid: got %0d pulses, required 1", validSeen - v0);
    end
    checkRegs("ldac_done");
    checkCounts("ldac_done");
  endtask

  task automatic test_reset_mid_frame();
    int v0 = validSeen;
    int e0 = errSeen;
    shiftBits(32'h0000_0A5A, 12);
    Reset = 1'b1;
    tick(3);
    resetModel();
    Reset = 1'b0;
    clockBits(32'h0000_05A5, 12);
    endFrame();
    tick(12);
    testsRun++;
    if (errSeen !== e0 || validSeen !== v0) begin
      testsFailed++;
      $display("FAIL reset_mid_events: got errLen=%0d valid=%0d, required 0 and 0",
               errSeen - e0, validSeen - v0);
    end
    testsRun++;
    if (errZero !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_mid_errZero: got %0d, required 0", errZero);
    end
    checkCounts("reset_mid_tail");
    sendFrame(24'h030042, 1'b1);
    checkRegs("reset_mid_frame");
    checkCounts("reset_mid_frame");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_broadcast();
    test_framing_errors();
    test_decode_only();
    test_clear();
    test_ldac_done();
    test_reset_mid_frame();
    tick(5);
    testsRun++;
    if (expQ.size() !== 0) begin
      testsFailed++;
      $display("FAIL scoreboard_leftover: got %0d pending frames, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
